// File: rtl/seq_multiplier_if.sv
// Operand/result bundle between the register-file read side, the iterative
// multiplier and the writeback mux.
interface seq_multiplier_if #(
  parameter int WIDTH = 64
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [4:0]       RWIn;
  logic             Ready;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [4:0]       ResultRW;

  modport master (
    output Start, Op, OpA, OpB, RWIn,
    input  Ready, Busy, Done, Result, ResultRW
  );

  modport slave (
    input  Start, Op, OpA, OpB, RWIn,
    output Ready, Busy, Done, Result, ResultRW
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add 64x64 multiplier (MUL / UMULH / SMULH), one product bit per
// clock; a final FIX cycle applies the sign and selects the result half.
module seq_multiplier #(
  parameter int WIDTH = 64,
  parameter int CNTW  = 6
) (
  input  logic          Clk,
  input  logic          Reset_n,
  seq_multiplier_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_SMULH = 2'b10;

  logic [1:0]         state;
  logic [CNTW-1:0]    cnt;
  logic [1:0]         opReg;
  logic [4:0]         rwReg;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   resultReg;
  logic [4:0]         resultRwReg;

  logic               isSigned;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   fixResult;

  // SMULH runs unsigned on magnitudes; -2^63 negates to itself, which is the
  // correct unsigned magnitude.
  assign isSigned = (bus.Op == OP_SMULH);
  assign absA     = (isSigned && bus.OpA[WIDTH-1]) ? -bus.OpA : bus.OpA;
  assign absB     = (isSigned && bus.OpB[WIDTH-1]) ? -bus.OpB : bus.OpB;

  assign addend    = mplier[0] ? mcand : '0;
  assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign prodFix   = neg ? -acc : acc;
  assign fixResult = (opReg == OP_UMULH || opReg == OP_SMULH) ?
                     prodFix[2*WIDTH-1:WIDTH] : prodFix[WIDTH-1:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      opReg       <= '0;
      rwReg       <= '0;
      mcand       <= '0;
      mplier      <= '0;
      neg         <= 1'b0;
      acc         <= '0;
      resultReg   <= '0;
      resultRwReg <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.Start) begin
            opReg  <= bus.Op;
            rwReg  <= bus.RWIn;
            mcand  <= absA;
            mplier <= absB;
            neg    <= isSigned & (bus.OpA[WIDTH-1] ^ bus.OpB[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          // Shift {carry, acc} right: the carry lands in acc's MSB.
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CNTW'(1);
          if (cnt == '1) state <= FIX;
        end
        FIX: begin
          resultReg   <= fixResult;
          resultRwReg <= rwReg;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Ready    = (state == IDLE) || (state == DONE);
  assign bus.Busy     = (state == RUN)  || (state == FIX);
  assign bus.Done     = (state == DONE);
  assign bus.Result   = resultReg;
  assign bus.ResultRW = resultRwReg;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: latency, arithmetic corners, Start
// handling during RUN, back-to-back throughput and mid-operation reset.
module tb_seq_multiplier;
  logic Clk;
  logic Reset_n;
  int   nCompared;
  int   nMismatched;

  seq_multiplier_if #(.WIDTH(64)) mulIf ();

  seq_multiplier #(.WIDTH(64), .CNTW(6)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (mulIf.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Launch one op, scramble operands after acceptance, wait (bounded) for Done.
  task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rw, output int lat, output int busyCyc,
                        output logic [63:0] res, output logic [4:0] rwo);
    @(negedge Clk);
    mulIf.Op = op; mulIf.OpA = a; mulIf.OpB = b; mulIf.RWIn = rw; mulIf.Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    mulIf.Start = 1'b0;
    mulIf.OpA = {$urandom, $urandom};
    mulIf.OpB = {$urandom, $urandom};
    mulIf.RWIn = 5'($urandom);
    lat = 0; busyCyc = 0;
    for (int c = 1; c <= 200; c++) begin
      if (mulIf.Done) begin
        lat = c;
        break;
      end
      if (mulIf.Busy) busyCyc++;
      @(negedge Clk);
    end
    res = mulIf.Result;
    rwo = mulIf.ResultRW;
    $display("op=%0d a=%h b=%h rw=%0d -> result=%h rw=%0d latency=%0d", op, a, b, rw, res, rwo, lat);
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    mulIf.Start = 1'b0; mulIf.Op = 2'b00; mulIf.OpA = '0; mulIf.OpB = '0; mulIf.RWIn = '0;
    repeat (3) @(negedge Clk);
    nCompared += 5;
    if (mulIf.Ready !== 1'b1) begin nMismatched++; $display("FAIL reset_ready: got %b expected 1", mulIf.Ready); end
    if (mulIf.Busy !== 1'b0) begin nMismatched++; $display("FAIL reset_busy: got %b expected 0", mulIf.Busy); end
    if (mulIf.Done !== 1'b0) begin nMismatched++; $display("FAIL reset_done: got %b expected 0", mulIf.Done); end
    if (mulIf.Result !== 64'd0) begin nMismatched++; $display("FAIL reset_result: got %h expected 0", mulIf.Result); end
    if (mulIf.ResultRW !== 5'd0) begin nMismatched++; $display("FAIL reset_rw: got %0d expected 0", mulIf.ResultRW); end
    $display("reset: ready=%b busy=%b done=%b result=%h rw=%0d", mulIf.Ready, mulIf.Busy, mulIf.Done, mulIf.Result, mulIf.ResultRW);
    Reset_n = 1'b1;
  endtask

  task automatic test_mul;
    int lat, busyCyc;
    logic [63:0] res;
    logic [4:0] rwo;
    run_op(2'b00, 64'd7, 64'd6, 5'd3, lat, busyCyc, res, rwo);
    nCompared += 4;
    if (lat !== 66) begin nMismatched++; $display("FAIL mul_latency: got %0d expected 66", lat); end
    if (busyCyc !== 65) begin nMismatched++; $display("FAIL mul_busy_cycles: got %0d expected 65", busyCyc); end
    if (res !== 64'd42) begin nMismatched++; $display("FAIL mul_result: got %h expected %h", res, 64'd42); end
    if (rwo !== 5'd3) begin nMismatched++; $display("FAIL mul_rw: got %0d expected 3", rwo); end
    @(negedge Clk);
    nCompared++;
    if (mulIf.Done !== 1'b0) begin nMismatched++; $display("FAIL mul_done_width: got %b expected 0", mulIf.Done); end
  endtask

  task automatic test_umulh;
    int lat, busyCyc;
    logic [63:0] res;
    logic [4:0] rwo;
    run_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, lat, busyCyc, res, rwo);
    nCompared += 3;
    if (lat !== 66) begin nMismatched++; $display("FAIL umulh_latency: got %0d expected 66", lat); end
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin nMismatched++; $display("FAIL umulh_result: got %h expected fffffffffffffffe", res); end
    if (rwo !== 5'd10) begin nMismatched++; $display("FAIL umulh_rw: got %0d expected 10", rwo); end
    run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, lat, busyCyc, res, rwo);
    nCompared += 2;
    if (lat !== 66) begin nMismatched++; $display("FAIL mul_ones_latency: got %0d expected 66", lat); end
    if (res !== 64'd1) begin nMismatched++; $display("FAIL mul_ones_result: got %h expected 1", res); end
  endtask

  task automatic test_smulh;
    logic [63:0] aTab [5];
    logic [63:0] bTab [5];
    logic [63:0] eTab [5];
    int lat, busyCyc;
    logic [63:0] res;
    logic [4:0] rwo;
    aTab[0] = 64'h8000_0000_0000_0000; bTab[0] = 64'h8000_0000_0000_0000; eTab[0] = 64'h4000_0000_0000_0000;
    aTab[1] = 64'h8000_0000_0000_0000; bTab[1] = 64'd1;                   eTab[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    aTab[2] = 64'hFFFF_FFFF_FFFF_FFFF; bTab[2] = 64'd5;                   eTab[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    aTab[3] = 64'h7FFF_FFFF_FFFF_FFFF; bTab[3] = 64'd2;                   eTab[3] = 64'd0;
    aTab[4] = 64'h8000_0000_0000_0000; bTab[4] = 64'hFFFF_FFFF_FFFF_FFFF; eTab[4] = 64'd0;
    for (int i = 0; i < 5; i++) begin
      run_op(2'b10, aTab[i], bTab[i], 5'(i + 20), lat, busyCyc, res, rwo);
      nCompared += 3;
      if (lat !== 66) begin nMismatched++; $display("FAIL smulh%0d_latency: got %0d expected 66", i, lat); end
      if (res !== eTab[i]) begin nMismatched++; $display("FAIL smulh%0d_result: got %h expected %h", i, res, eTab[i]); end
      if (rwo !== 5'(i + 20)) begin nMismatched++; $display("FAIL smulh%0d_rw: got %0d expected %0d", i, rwo, i + 20); end
    end
  endtask

  task automatic test_reserved_xzr;
    int lat, busyCyc;
    logic [63:0] res;
    logic [4:0] rwo;
    run_op(2'b11, 64'd5, 64'd9, 5'd31, lat, busyCyc, res, rwo);
    nCompared += 3;
    if (lat !== 66) begin nMismatched++; $display("FAIL reserved_latency: got %0d expected 66", lat); end
    if (res !== 64'd45) begin nMismatched++; $display("FAIL reserved_result: got %h expected %h", res, 64'd45); end
    if (rwo !== 5'd31) begin nMismatched++; $display("FAIL xzr_rw: got %0d expected 31", rwo); end
  endtask

  task automatic test_start_ignored;
    int doneCnt, doneAt;
    logic [63:0] res;
    @(negedge Clk);
    mulIf.Op = 2'b00; mulIf.OpA = 64'd11; mulIf.OpB = 64'd13; mulIf.RWIn = 5'd4; mulIf.Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    mulIf.Start = 1'b0;
    doneCnt = 0; doneAt = 0; res = '0;
    for (int c = 1; c <= 150; c++) begin
      if (c == 20) begin
        mulIf.OpA = 64'd100; mulIf.OpB = 64'd200; mulIf.RWIn = 5'd7; mulIf.Start = 1'b1;
      end
      if (c == 21) mulIf.Start = 1'b0;
      if (mulIf.Done) begin
        doneCnt++;
        if (doneAt == 0) begin doneAt = c; res = mulIf.Result; end
      end
      @(negedge Clk);
    end
    $display("start_ignored: done_count=%0d done_at=%0d result=%h", doneCnt, doneAt, res);
    nCompared += 3;
    if (doneCnt !== 1) begin nMismatched++; $display("FAIL ignored_done_count: got %0d expected 1", doneCnt); end
    if (doneAt !== 66) begin nMismatched++; $display("FAIL ignored_latency: got %0d expected 66", doneAt); end
    if (res !== 64'd143) begin nMismatched++; $display("FAIL ignored_result: got %h expected %h", res, 64'd143); end
  endtask

  task automatic test_back_to_back;
    int doneCnt, prevDone;
    @(negedge Clk);
    mulIf.Op = 2'b00; mulIf.OpA = 64'd3; mulIf.OpB = 64'd4; mulIf.RWIn = 5'd8; mulIf.Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    doneCnt = 0; prevDone = 0;
    for (int c = 1; c <= 300; c++) begin
      if (mulIf.Done) begin
        doneCnt++;
        $display("back_to_back: done #%0d at cycle %0d result=%h", doneCnt, c, mulIf.Result);
        nCompared += 2;
        if (c - prevDone !== 66) begin nMismatched++; $display("FAIL b2b_gap%0d: got %0d expected 66", doneCnt, c - prevDone); end
        if (mulIf.Result !== 64'd12) begin nMismatched++; $display("FAIL b2b_result%0d: got %h expected %h", doneCnt, mulIf.Result, 64'd12); end
        prevDone = c;
        if (doneCnt == 3) begin
          mulIf.Start = 1'b0;
          break;
        end
      end
      @(negedge Clk);
    end
    mulIf.Start = 1'b0;
    nCompared++;
    if (doneCnt !== 3) begin nMismatched++; $display("FAIL b2b_done_count: got %0d expected 3", doneCnt); end
  endtask

  task automatic test_reset_mid;
    int lat, busyCyc, early;
    logic [63:0] res;
    logic [4:0] rwo;
    @(negedge Clk);
    mulIf.Op = 2'b00; mulIf.OpA = 64'd7; mulIf.OpB = 64'd6; mulIf.RWIn = 5'd5; mulIf.Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    mulIf.Start = 1'b0;
    repeat (29) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    $display("reset_mid: ready=%b busy=%b done=%b result=%h rw=%0d", mulIf.Ready, mulIf.Busy, mulIf.Done, mulIf.Result, mulIf.ResultRW);
    nCompared += 5;
    if (mulIf.Ready !== 1'b1) begin nMismatched++; $display("FAIL midrst_ready: got %b expected 1", mulIf.Ready); end
    if (mulIf.Busy !== 1'b0) begin nMismatched++; $display("FAIL midrst_busy: got %b expected 0", mulIf.Busy); end
    if (mulIf.Done !== 1'b0) begin nMismatched++; $display("FAIL midrst_done: got %b expected 0", mulIf.Done); end
    if (mulIf.Result !== 64'd0) begin nMismatched++; $display("FAIL midrst_result: got %h expected 0", mulIf.Result); end
    if (mulIf.ResultRW !== 5'd0) begin nMismatched++; $display("FAIL midrst_rw: got %0d expected 0", mulIf.ResultRW); end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    early = 0;
    for (int c = 0; c < 80; c++) begin
      if (mulIf.Done) early++;
      @(negedge Clk);
    end
    nCompared++;
    if (early !== 0) begin nMismatched++; $display("FAIL midrst_stray_done: got %0d expected 0", early); end
    run_op(2'b00, 64'd2, 64'd2, 5'd9, lat, busyCyc, res, rwo);
    nCompared += 3;
    if (lat !== 66) begin nMismatched++; $display("FAIL midrst_latency: got %0d expected 66", lat); end
    if (res !== 64'd4) begin nMismatched++; $display("FAIL midrst_result_after: got %h expected 4", res); end
    if (rwo !== 5'd9) begin nMismatched++; $display("FAIL midrst_rw_after: got %0d expected 9", rwo); end
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    test_reset();
    test_mul();
    test_umulh();
    test_smulh();
    test_reserved_xzr();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
